fm_phase_discriminator: RTL and testbench

- Sits directly downstream of the CORDIC angle block in the receive chain.
- Consumes one 16-bit signed angle per CORDIC conversion and forms the wrapped phase difference between consecutive samples (instantaneous frequency).
- Integrates and dumps DECIM differences, then emits a frequency word plus a hard-sliced data bit for the downstream bit-sync logic.

---
 rtl/fm_phase_discriminator_pkg.sv | 17 +
 rtl/fm_phase_discriminator_if.sv | 26 ++
 rtl/fm_phase_discriminator_phase_wrap_diff.sv | 24 ++
 rtl/fm_phase_discriminator.sv | 80 ++++++++
 tb/tb_fm_phase_discriminator.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fm_phase_discriminator_pkg.sv
// Shared types and constants for the FM phase discriminator and related receive-chain blocks.
// Angles are in 1/128 degree units, so +-180 degrees is +-23040.
package fm_phase_discriminator_pkg;

  localparam int ANG_W  = 16;
  localparam int DIFF_W = 17;

  typedef logic signed [ANG_W-1:0]  angle_t;
  typedef logic signed [DIFF_W-1:0] diff_t;

  localparam diff_t ANG_180 = 17'sd23040;
  localparam diff_t ANG_360 = 17'sd46080;

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/fm_phase_discriminator_if.sv
// Angle-in / frequency-out bundle between the CORDIC side, the discriminator and bit-sync.
interface fm_phase_discriminator_if #(
  parameter int ACC_W = 21
);
  import fm_phase_discriminator_pkg::*;

  logic                    cordic_done;
  angle_t                  angle_in;
  logic                    clear;
  logic signed [ACC_W-1:0] threshold;
  logic signed [ACC_W-1:0] freq_out;
  logic                    freq_valid;
  logic                    bit_out;
  logic                    primed;

  modport master (
    output cordic_done, angle_in, clear, threshold,
    input  freq_out, freq_valid, bit_out, primed
  );

  modport slave (
    input  cordic_done, angle_in, clear, threshold,
    output freq_out, freq_valid, bit_out, primed
  );

endinterface

// File: rtl/fm_phase_discriminator_phase_wrap_diff.sv
// Wrapped difference of two angles, folded into [-180, +180] degrees.
// Exactly +-180 degrees passes through unchanged.
module phase_wrap_diff
  import fm_phase_discriminator_pkg::*;
(
  input  angle_t angle_in,
  input  angle_t prev_angle,
  output diff_t  diff
);

  diff_t raw;

  // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    raw = diff_t'(angle_in) - diff_t'(prev_angle);
    if (raw > ANG_180)
      diff = raw - ANG_360;
    else if (raw < -ANG_180)
      diff = raw + ANG_360;
    else
      diff = raw;
  end

endmodule

// File: rtl/fm_phase_discriminator.sv
// Integrate-and-dump FM discriminator: sums DECIM wrapped phase differences between
// consecutive CORDIC angles and slices the sum against a threshold.
module fm_phase_discriminator
  import fm_phase_discriminator_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int ACC_W = 21
) (
  input logic                      clk,
  input logic                      reset,
  fm_phase_discriminator_if.slave  bus
);

  localparam logic [3:0] CNT_LAST = 4'(DECIM - 1);

  logic                    done_d;
  logic [0:0]              state;
  angle_t                  prev_angle;
  logic signed [ACC_W-1:0] acc;
  logic [3:0]              cnt;
  logic signed [ACC_W-1:0] freq_q;
  logic                    valid_q;
  logic                    bit_q;

  diff_t                   diff;
  logic signed [ACC_W-1:0] sum;
  logic                    sample;

  phase_wrap_diff u_wrap (
    .angle_in   (bus.angle_in),
    .prev_angle (prev_angle),
    .diff       (diff)
  );

  assign sample = bus.cordic_done & ~done_d;
  assign sum    = acc + {{(ACC_W-DIFF_W){diff[DIFF_W-1]}}, diff};

  // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // done_d comes out of reset high so the upstream block's own post-reset done edge is ignored.
      done_d     <= 1'b1;
      state      <= ST_PRIME;
      prev_angle <= '0;
      acc        <= '0;
      cnt        <= '0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      done_d  <= bus.cordic_done;
      valid_q <= 1'b0;
      if (bus.clear) begin
        state <= ST_PRIME;
        acc   <= '0;
        cnt   <= '0;
      end else if (sample) begin
        prev_angle <= bus.angle_in;
        if (state == ST_PRIME) begin
          state <= ST_RUN;
        end else if (cnt == CNT_LAST) begin
          freq_q  <= sum;
          bit_q   <= (sum > bus.threshold);
          valid_q <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  assign bus.freq_out   = freq_q;
  assign bus.freq_valid = valid_q;
  assign bus.bit_out    = bit_q;
  assign bus.primed     = (state == ST_RUN);

endmodule

// File: tb/tb_fm_phase_discriminator.sv
// Scoreboard bench: stimulus pushes hand-computed expected dumps, a negedge monitor pops and compares.
// Two instances: DECIM=4 for integrate/clear/reset cases, DECIM=1 for wrap and slicer cases.
module tb_fm_phase_discriminator;
  import fm_phase_discriminator_pkg::*;

  localparam int ACC_W = 21;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fm_phase_discriminator_if #(.ACC_W(ACC_W)) if4 ();
  fm_phase_discriminator_if #(.ACC_W(ACC_W)) if1 ();

  fm_phase_discriminator #(.DECIM(4), .ACC_W(ACC_W)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  fm_phase_discriminator #(.DECIM(1), .ACC_W(ACC_W)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  typedef struct {
    longint freq;
    logic   bit_v;
    longint cyc;
  } exp_t;

  exp_t   q4[$];
  exp_t   q1[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e4, e1;
    if (if4.freq_valid === 1'b1) begin
      if (q4.size() == 0) check("d4_spurious_valid", if4.freq_valid, 0);
      else begin
        e4 = q4.pop_front();
        check("d4_freq", if4.freq_out, e4.freq);
        check("d4_bit", if4.bit_out, e4.bit_v);
        check("d4_latency", cyc, e4.cyc);
      end
    end
    if (if1.freq_valid === 1'b1) begin
      if (q1.size() == 0) check("d1_spurious_valid", if1.freq_valid, 0);
      else begin
        e1 = q1.pop_front();
        check("d1_freq", if1.freq_out, e1.freq);
        check("d1_bit", if1.bit_out, e1.bit_v);
        check("d1_latency", cyc, e1.cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One done edge on the DECIM=4 instance; done is held for 'hold' cycles, clear only on the edge cycle.
  task automatic send4(input angle_t a, input bit dump, input longint f = 0, input bit b = 0,
                       input int hold = 1, input bit clr = 0);
    if4.angle_in    = a;
    if4.cordic_done = 1'b1;
    if4.clear       = clr;
    if (dump) q4.push_back('{freq: f, bit_v: b, cyc: cyc + 1});
    tick(1);
    if4.clear = 1'b0;
    if (hold > 1) tick(hold - 1);
    if4.cordic_done = 1'b0;
    tick(1);
  endtask

  task automatic send1(input angle_t a, input bit dump, input longint f = 0, input bit b = 0);
    if1.angle_in    = a;
    if1.cordic_done = 1'b1;
    if (dump) q1.push_back('{freq: f, bit_v: b, cyc: cyc + 1});
    tick(1);
    if1.cordic_done = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1;
    if4.cordic_done = 1'b0; if4.angle_in = '0; if4.clear = 1'b0; if4.threshold = '0;
    if1.cordic_done = 1'b0; if1.angle_in = '0; if1.clear = 1'b0; if1.threshold = '0;
    tick(3);

    // Reset release with done rising on the first cycle: must not count as a sample.
    reset = 1'b0;
    if4.cordic_done = 1'b1;
    if1.cordic_done = 1'b1;
    tick(5);
    check("rst_primed4", if4.primed, 0);
    check("rst_primed1", if1.primed, 0);
    check("rst_freq4", if4.freq_out, 0);
    check("rst_bit4", if4.bit_out, 0);
    check("rst_valid4", if4.freq_valid, 0);
    if4.cordic_done = 1'b0;
    if1.cordic_done = 1'b0;
    tick(2);
    check("post_rst_primed4", if4.primed, 0);

    // +10 degree steps: four diffs of 1280.
    send4(0, 0);
    check("primed_after_first4", if4.primed, 1);
    send4(1280, 0);
    send4(2560, 0);
    send4(3840, 0);
    send4(5120, 1, 5120, 1);

    // Done held high for 20 cycles counts once.
    send4(5220, 0, 0, 0, 20);
    send4(5320, 0);
    send4(5420, 0);
    send4(5520, 1, 400, 1);

    // Clear on the third sample edge; freq_out holds, next edge re-primes.
    send4(5620, 0);
    send4(5720, 0);
    send4(5820, 0, 0, 0, 1, 1);
    check("clear_primed4", if4.primed, 0);
    check("clear_hold_freq4", if4.freq_out, 400);
    send4(1000, 0);
    check("reprime4", if4.primed, 1);
    send4(500, 0);
    send4(0, 0);
    send4(-500, 0);
    send4(-1000, 1, -2000, 0);

    // Clear coinciding with the dump edge suppresses the output.
    send4(-900, 0);
    send4(-800, 0);
    send4(-700, 0);
    send4(-600, 0, 0, 0, 1, 1);
    check("clear_dump_primed4", if4.primed, 0);
    check("clear_dump_hold4", if4.freq_out, -2000);

    // Reset after two accumulated diffs, then -10 degree steps.
    send4(0, 0);
    send4(1280, 0);
    send4(2560, 0);
    reset = 1'b1;
    tick(2);
    check("midrst_freq4", if4.freq_out, 0);
    check("midrst_bit4", if4.bit_out, 0);
    check("midrst_primed4", if4.primed, 0);
    reset = 1'b0;
    tick(1);
    send4(0, 0);
    send4(-1280, 0);
    send4(-2560, 0);
    send4(-3840, 0);
    send4(-5120, 1, -5120, 0);

    // DECIM=1 wrap cases and slicer boundary.
    send1(21760, 0);
    send1(-21760, 1, 2560, 1);
    send1(21760, 1, -2560, 0);
    send1(0, 1, -21760, 0);
    if1.threshold = 21'sd23040;
    send1(23040, 1, 23040, 0);
    if1.threshold = -21'sd1;
    send1(-23040, 1, 0, 1);

    tick(5);
    check("q4_drained", q4.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
